// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   - uart_state_e   : serialiser FSM states
//   - UART_CYCLE_MAX : largest clocks-per-bit value the 16-bit bit timer holds
//   - uart_cycle()   : clocks per bit from clock (MHz) and baud rate,
//                      integer-truncated so TX and RX derive identical timing
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_SEND_BYTE = 2'd2,
    S_STOP      = 2'd3
  } uart_state_e;

  localparam int unsigned UART_CYCLE_MAX = 65535;

  // Clocks per bit. The product is formed in 64 bits so large clock
  // frequencies cannot overflow before the division.
  function automatic int unsigned uart_cycle(input int unsigned clk_mhz,
                                             input int unsigned baud);
    logic [63:0] clk_hz;
    if (baud == 0) begin
      return 0;
    end
    clk_hz = 64'(clk_mhz) * 64'd1000000;
    return 32'(clk_hz / 64'(baud));
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO feeding the UART serialiser.
// Parameters:
//   DEPTH      : number of entries, power of two, >= 2
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset (flushes the FIFO)
//   push       : write push_data this edge (ignored while full)
//   push_data  : byte to write
//   pop        : discard the head entry this edge (ignored while empty)
//   pop_data   : head entry, valid whenever !empty
//   full/empty : status, derived from the registered pointers only
//   level      : number of stored entries
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          push_ok;
  logic          pop_ok;

  // Pointers carry one extra MSB: equal indices with differing MSBs means
  // the write pointer has lapped the read pointer, i.e. full.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level = LW'(wr_ptr_q - rd_ptr_q);
  end

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset: a flush only moves the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  // Head is read asynchronously so the serialiser can pop and load its
  // shift register on the same edge, keeping frames back-to-back.
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered 8N1 UART transmitter. Bytes arrive on a valid/ready handshake,
// queue in uart_tx_fifo and are serialised LSB first with no idle gap
// between queued frames.
// Parameters:
//   CLK_FRE    : clock frequency in MHz
//   BAUD_RATE  : serial baud rate
//   FIFO_DEPTH : byte buffer depth, power of two, >= 2
// Ports:
//   clk           : clock
//   rst           : synchronous active-high reset
//   tx_data       : byte to send
//   tx_data_valid : tx_data is valid
//   tx_data_ready : FIFO not full (from registered state only)
//   tx_pin        : registered serial output, idle high
//   tx_busy       : registered, high while a frame is on the line
//   fifo_level    : bytes queued, excluding the one being sent
// ---------------------------------------------------------------------------
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 1500000,
  parameter int FIFO_DEPTH = 8,
  localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    tx_data,
  input  logic          tx_data_valid,
  output logic          tx_data_ready,
  output logic          tx_pin,
  output logic          tx_busy,
  output logic [LW-1:0] fifo_level
);

  localparam int unsigned CYCLE    = uart_cycle(CLK_FRE, BAUD_RATE);
  localparam logic [15:0] CYCLE_M1 = 16'(CYCLE - 1);

  if ((CYCLE > UART_CYCLE_MAX) || (CYCLE < 1)) begin : g_bad_cycle
    $error("uart_tx_buffered: clocks per bit must be within 1..65535");
  end

  uart_state_e state_q, state_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_pin_q, tx_pin_d;
  logic        tx_busy_q, tx_busy_d;

  logic        fifo_pop;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_data_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign tx_data_ready = !fifo_full;
  assign bit_end       = (cycle_cnt_q == CYCLE_M1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_pin_q    <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_pin_q    <= tx_pin_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q + 16'd1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    fifo_pop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cycle_cnt_d = '0;
        bit_cnt_d   = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          cycle_cnt_d = '0;
          bit_cnt_d   = '0;
          state_d     = S_SEND_BYTE;
        end
      end

      S_SEND_BYTE: begin
        if (bit_end) begin
          cycle_cnt_d = '0;
          shift_d     = {1'b0, shift_q[7:1]};
          bit_cnt_d   = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cycle_cnt_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit: no idle gap.
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        cycle_cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pin changes on
  // the same edge the FSM moves, e.g. the start bit appears one edge after a
  // byte lands in an empty FIFO.
  always_comb begin
    case (state_d)
      S_START:     tx_pin_d = 1'b0;
      S_SEND_BYTE: tx_pin_d = shift_d[0];
      default:     tx_pin_d = 1'b1;
    endcase
    tx_busy_d = (state_d != S_IDLE);
  end

  assign tx_pin  = tx_pin_q;
  assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
// Directed bench. Instance "a" runs at 10 clocks per bit (50 MHz, 5 Mbaud);
// instance "d" uses default parameters (33 clocks per bit by truncation).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic [7:0] a_data, d_data;
  logic       a_valid, d_valid;
  logic       a_ready, d_ready;
  logic       a_pin, d_pin;
  logic       a_busy, d_busy;
  logic [3:0] a_level, d_level;

  int checks = 0;
  int errors = 0;

  uart_tx_buffered #(
    .CLK_FRE    (50),
    .BAUD_RATE  (5000000),
    .FIFO_DEPTH (8)
  ) dut_a (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (a_data),
    .tx_data_valid (a_valid),
    .tx_data_ready (a_ready),
    .tx_pin        (a_pin),
    .tx_busy       (a_busy),
    .fifo_level    (a_level)
  );

  uart_tx_buffered dut_d (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (d_data),
    .tx_data_valid (d_valid),
    .tx_data_ready (d_ready),
    .tx_pin        (d_pin),
    .tx_busy       (d_busy),
    .fifo_level    (d_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] b;
  logic [7:0] rx;
  logic       exp_pin;
  logic       flag;
  logic       s_pin  [0:309];
  logic       s_busy [0:309];
  logic [7:0] burst  [0:2];
  int         acc_edge [0:9];
  int         n, e;
  logic       rdy;

  initial begin
    rst = 1'b1; a_valid = 1'b0; a_data = '0; d_valid = 1'b0; d_data = '0;

    // ---------------- reset ----------------
    repeat (3) tick();
    chk("rst_a_pin",   a_pin,   1);
    chk("rst_a_busy",  a_busy,  0);
    chk("rst_a_level", a_level, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_d_pin",   d_pin,   1);
    chk("rst_d_busy",  d_busy,  0);
    chk("rst_d_level", d_level, 0);
    chk("rst_d_ready", d_ready, 1);
    rst = 1'b0;
    flag = 1'b0;
    repeat (100) begin
      tick();
      if (!a_pin || !d_pin || a_busy || d_busy) flag = 1'b1;
    end
    chk("idle_quiet", flag, 0);
    $display("txn: reset released, line idle for 100 cycles");

    // ---------------- single byte 0x55 ----------------
    b = 8'h55;
    a_data = b; a_valid = 1'b1;
    tick();                       // edge k
    a_valid = 1'b0;
    chk("single_k_pin",   a_pin,   1);
    chk("single_k_level", a_level, 1);
    chk("single_k_busy",  a_busy,  0);
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i <= 10)      exp_pin = 1'b0;
      else if (i <= 90) exp_pin = b[(i - 11) / 10];
      else              exp_pin = 1'b1;
      chk($sformatf("single_pin_c%0d", i), a_pin, exp_pin);
      chk($sformatf("single_busy_c%0d", i), a_busy, 1);
    end
    tick();                       // edge k+101
    chk("single_busy_fall", a_busy, 0);
    chk("single_pin_idle",  a_pin,  1);
    $display("txn: single byte 55 framed");

    // ---------------- burst A3 0F FF ----------------
    burst[0] = 8'hA3; burst[1] = 8'h0F; burst[2] = 8'hFF;
    a_data = burst[0]; a_valid = 1'b1;
    tick();                       // edge k
    a_data = burst[1];
    tick();                       // edge k+1
    s_pin[0] = a_pin; s_busy[0] = a_busy;
    a_data = burst[2];
    tick();                       // edge k+2
    s_pin[1] = a_pin; s_busy[1] = a_busy;
    a_valid = 1'b0;
    for (int i = 2; i < 310; i++) begin
      tick();
      s_pin[i] = a_pin; s_busy[i] = a_busy;
    end
    for (int f = 0; f < 3; f++) begin
      chk($sformatf("burst_f%0d_start_edge", f), s_pin[f * 100], 0);
      chk($sformatf("burst_f%0d_start_mid", f), s_pin[f * 100 + 5], 0);
      for (int bi = 0; bi < 8; bi++) rx[bi] = s_pin[f * 100 + 10 * (bi + 1) + 5];
      chk($sformatf("burst_f%0d_data", f), rx, burst[f]);
      chk($sformatf("burst_f%0d_stop", f), s_pin[f * 100 + 95], 1);
      $display("txn: burst frame %0d decoded %02h", f, rx);
    end
    chk("burst_busy_last", s_busy[299], 1);
    chk("burst_busy_fall", s_busy[300], 0);
    flag = 1'b0;
    for (int i = 300; i < 310; i++) if (!s_pin[i]) flag = 1'b1;
    chk("burst_tail_idle", flag, 0);

    // ---------------- full FIFO ----------------
    n = 0; e = 0;
    for (int i = 0; i < 10; i++) acc_edge[i] = -1;
    while (n < 10 && e < 300) begin
      a_data = 8'h10 + 8'(n); a_valid = 1'b1;
      rdy = a_ready;
      tick();                     // edge k+e
      if (rdy) begin
        acc_edge[n] = e;
        n++;
      end
      if (e == 8) begin
        chk("full_level_8", a_level, 8);
        chk("full_ready_low", a_ready, 0);
      end
      e++;
    end
    a_valid = 1'b0;
    for (int i = 0; i < 9; i++) chk($sformatf("full_accept_b%0d", i + 1), acc_edge[i], i);
    chk("full_accept_b10", acc_edge[9], 102);
    $display("txn: full test, byte 10 accepted at edge offset %0d", acc_edge[9]);
    n = 0;
    while ((a_busy || a_level != 0) && n < 1500) begin
      tick();
      n++;
    end
    chk("full_drain_timeout", (n < 1500), 1);
    chk("full_drain_level", a_level, 0);

    // ---------------- reset mid-frame ----------------
    a_valid = 1'b1;
    a_data = 8'h11; tick();       // edge k
    a_data = 8'h22; tick();       // edge k+1, frame cycle 0
    a_data = 8'h33; tick();       // edge k+2
    a_valid = 1'b0;
    repeat (43) tick();           // edge k+45, frame cycle 44 (bit 3 of 0x11)
    chk("midrst_pre_pin",   a_pin,   0);
    chk("midrst_pre_level", a_level, 2);
    rst = 1'b1;
    tick();                       // edge k+46, frame cycle 45
    chk("midrst_pin",   a_pin,   1);
    chk("midrst_level", a_level, 0);
    chk("midrst_busy",  a_busy,  0);
    chk("midrst_ready", a_ready, 1);
    rst = 1'b0;
    flag = 1'b0;
    repeat (200) begin
      tick();
      if (!a_pin || a_busy || a_level != 0) flag = 1'b1;
    end
    chk("midrst_quiet", flag, 0);
    $display("txn: reset mid-frame flushed queue");

    // ---------------- default parameters, 0x00 ----------------
    d_data = 8'h00; d_valid = 1'b1;
    tick();                       // edge k
    d_valid = 1'b0;
    chk("dflt_k_pin", d_pin, 1);
    for (int i = 1; i <= 330; i++) begin
      tick();
      exp_pin = (i <= 297) ? 1'b0 : 1'b1;
      chk($sformatf("dflt_pin_c%0d", i), d_pin, exp_pin);
    end
    chk("dflt_busy_last", d_busy, 1);
    tick();                       // edge k+331
    chk("dflt_busy_fall", d_busy, 0);
    chk("dflt_pin_idle",  d_pin,  1);
    $display("txn: default-rate byte 00 framed in 330 cycles");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
